lock_controller: RTL and testbench
==================================

LOCK_CONTROLLER -- requirements
Module: lock_controller

Interface
REQ-001 Parameter ENTRY_CYCLES, 200, inactivity window (clk cycles) before an entry attempt fails; legal range 1..65535.
REQ-002 Parameter OPEN_CYCLES, 1000, duration of unlocked indication; legal range 1..65535.
REQ-003 Parameter LOCKOUT_CYCLES, 5000, duration of lockout; legal range 1..65535.
REQ-004 Parameter MAX_FAIL, 3, consecutive failed attempts that trigger lockout; legal range 1..3.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 left  input  1  debounced left button level.
REQ-008 right  input  1  debounced right button level.
REQ-009 match  input  1  single-cycle pulse from the sequence detector on a completed code.
REQ-010 det_left  output  1  gated left button level forwarded to the detector.
REQ-011 det_right  output  1  gated right button level forwarded to the detector.
REQ-012 det_clr  output  1  active-high detector clear.
REQ-013 unlocked  output  1  high while in OPEN.
REQ-014 alarm  output  1  high while in LOCKOUT.
REQ-015 fail_cnt  output  2  current consecutive failure count.
REQ-016 state  output  2  encoding: ARMED=0, ENTRY=1, OPEN=2, LOCKOUT=3.

Function
REQ-017 Edge detection SHALL use registered copies of left/right; a press SHALL be a 0->1 transition on either input; these registers SHALL update every cycle in every state.
REQ-018 det_left/det_right SHALL equal left/right combinationally in ARMED and ENTRY, and SHALL be 0 in OPEN and LOCKOUT.
REQ-019 A single 16-bit down-counter SHALL time ENTRY, OPEN and LOCKOUT; on entry to a state of N cycles it SHALL load N-1, and the state SHALL last exactly N cycles.
REQ-020 ARMED: match -> OPEN; otherwise a press -> ENTRY with the timer loaded with ENTRY_CYCLES-1.
REQ-021 ENTRY: match -> OPEN; a press SHALL reload ENTRY_CYCLES-1 and stay in ENTRY; timer at 0 with no press and no match -> failure.
REQ-022 Priority in ENTRY SHALL be match > press > expiry; a press in the expiry cycle is not a failure.
REQ-023 Failure: if fail_cnt+1 == MAX_FAIL, go to LOCKOUT with fail_cnt=MAX_FAIL; else go to ARMED with fail_cnt incremented.
REQ-024 OPEN: unlocked=1 for OPEN_CYCLES, then ARMED; fail_cnt SHALL clear on entry to OPEN.
REQ-025 LOCKOUT: alarm=1 for LOCKOUT_CYCLES, then ARMED with fail_cnt=0; match and presses SHALL be ignored.
REQ-026 det_clr SHALL pulse high for exactly one cycle, the first cycle after any transition into ARMED.
REQ-027 A button held through an OPEN or LOCKOUT exit SHALL NOT count as a press in ARMED.
REQ-028 unlocked, alarm, state and fail_cnt SHALL be decoded from registers, with no combinational path from inputs.

Reset
REQ-029 While rst=1 at a clock edge: state=ARMED, fail_cnt=0, timer=0, edge registers=0, unlocked=0, alarm=0, det_clr=1.
REQ-030 det_clr SHALL remain high for the first cycle after rst deasserts, then drop to 0.
REQ-031 rst asserted in any state, including mid-OPEN or mid-LOCKOUT, SHALL abort to the reset values at the next edge.

Verification (ENTRY_CYCLES=8, OPEN_CYCLES=4, LOCKOUT_CYCLES=6, MAX_FAIL=3)
REQ-032 Reset release -> state=0, fail_cnt=0, det_clr high for one cycle, outputs 0.
REQ-033 Press left, match 3 cycles later -> state=2, unlocked high for exactly 4 cycles, then state=0, det_clr pulse, fail_cnt=0.
REQ-034 Three press-then-idle attempts -> fail_cnt 1, 2, then state=3, alarm high for 6 cycles, det_left/det_right=0 throughout, then state=0, fail_cnt=0.
REQ-035 In ENTRY, press in the same cycle the timer reaches 0 -> no failure, timer reloads to 7; match coincident with expiry -> OPEN.
REQ-036 rst pulse during the third LOCKOUT cycle -> alarm=0, state=0, fail_cnt=0 next cycle; left held high across the LOCKOUT exit -> state stays 0.

Source files
------------

// File: rtl/lock_controller.sv
// Two-button code lock supervisor: gates buttons to an external sequence detector,
// times entry attempts, the unlocked window and the failure lockout with one shared down-counter.
module lock_controller #(
    parameter int unsigned ENTRY_CYCLES   = 200,
    parameter int unsigned OPEN_CYCLES    = 1000,
    parameter int unsigned LOCKOUT_CYCLES = 5000,
    parameter int unsigned MAX_FAIL       = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       left,
    input  logic       right,
    input  logic       match,
    output logic       det_left,
    output logic       det_right,
    output logic       det_clr,
    output logic       unlocked,
    output logic       alarm,
    output logic [1:0] fail_cnt,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        ST_ARMED   = 2'd0,
        ST_ENTRY   = 2'd1,
        ST_OPEN    = 2'd2,
        ST_LOCKOUT = 2'd3
    } state_t;

    localparam logic [15:0] ENTRY_LOAD   = 16'(ENTRY_CYCLES - 1);
    localparam logic [15:0] OPEN_LOAD    = 16'(OPEN_CYCLES - 1);
    localparam logic [15:0] LOCKOUT_LOAD = 16'(LOCKOUT_CYCLES - 1);
    localparam logic [2:0]  MAX_FAIL_V   = 3'(MAX_FAIL);

    state_t      state_q, state_d;
    logic [15:0] timer_q, timer_d;
    logic [1:0]  fail_q, fail_d;
    logic        left_q, right_q;
    logic        det_clr_q, det_clr_d;
    logic        press;

    // Edge registers track the raw buttons in every state, so a button held
    // through an OPEN/LOCKOUT exit is already "seen" and cannot look like a press.
    assign press = (left & ~left_q) | (right & ~right_q);

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        fail_d    = fail_q;
        det_clr_d = 1'b0;
        case (state_q)
            ST_ARMED: begin
                if (match) begin
                    state_d = ST_OPEN;
                    timer_d = OPEN_LOAD;
                    fail_d  = 2'd0;
                end else if (press) begin
                    state_d = ST_ENTRY;
                    timer_d = ENTRY_LOAD;
                end
            end
            ST_ENTRY: begin
                if (match) begin
                    state_d = ST_OPEN;
                    timer_d = OPEN_LOAD;
                    fail_d  = 2'd0;
                end else if (press) begin
                    timer_d = ENTRY_LOAD;
                end else if (timer_q == 16'd0) begin
                    if (({1'b0, fail_q} + 3'd1) == MAX_FAIL_V) begin
                        state_d = ST_LOCKOUT;
                        timer_d = LOCKOUT_LOAD;
                        fail_d  = MAX_FAIL_V[1:0];
                    end else begin
                        state_d = ST_ARMED;
                        fail_d  = fail_q + 2'd1;
                    end
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            ST_OPEN: begin
                if (timer_q == 16'd0) begin
                    state_d = ST_ARMED;
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            default: begin
                if (timer_q == 16'd0) begin
                    state_d = ST_ARMED;
                    fail_d  = 2'd0;
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
        endcase
        if ((state_d == ST_ARMED) && (state_q != ST_ARMED)) begin
            det_clr_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_ARMED;
            timer_q   <= 16'd0;
            fail_q    <= 2'd0;
            left_q    <= 1'b0;
            right_q   <= 1'b0;
            det_clr_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            fail_q    <= fail_d;
            left_q    <= left;
            right_q   <= right;
            det_clr_q <= det_clr_d;
        end
    end

    assign det_left  = left  & ~state_q[1];
    assign det_right = right & ~state_q[1];
    assign det_clr   = det_clr_q;
    assign unlocked  = (state_q == ST_OPEN);
    assign alarm     = (state_q == ST_LOCKOUT);
    assign fail_cnt  = fail_q;
    assign state     = state_q;

endmodule

// File: tb/tb_lock_controller.sv
// Bench for lock_controller: directed scenarios plus random traffic, checked every
// cycle against a deadline-based behavioural model.
module tb_lock_controller;

    localparam int E  = 8;
    localparam int O  = 4;
    localparam int L  = 6;
    localparam int MF = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       left = 1'b0;
    logic       right = 1'b0;
    logic       match = 1'b0;
    logic       det_left, det_right, det_clr, unlocked, alarm;
    logic [1:0] fail_cnt, state;

    lock_controller #(
        .ENTRY_CYCLES(E), .OPEN_CYCLES(O), .LOCKOUT_CYCLES(L), .MAX_FAIL(MF)
    ) dut (
        .clk(clk), .rst(rst), .left(left), .right(right), .match(match),
        .det_left(det_left), .det_right(det_right), .det_clr(det_clr),
        .unlocked(unlocked), .alarm(alarm), .fail_cnt(fail_cnt), .state(state)
    );

    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    // Model: mode 0..3, absolute deadline edge index for timed modes.
    int m_mode  = 0;
    int m_end   = 0;
    int m_fails = 0;
    int now     = 0;
    bit m_pl = 1'b0, m_pr = 1'b0, m_clr = 1'b1, m_valid = 1'b0;

    always @(posedge clk) begin : model
        int  old;
        bit  press;
        if (rst) begin
            m_mode = 0; m_fails = 0; m_pl = 1'b0; m_pr = 1'b0; m_clr = 1'b1; m_valid = 1'b1;
        end else if (m_valid) begin
            press = (left && !m_pl) || (right && !m_pr);
            m_pl = left;
            m_pr = right;
            old  = m_mode;
            if ((m_mode == 0 || m_mode == 1) && match) begin
                m_mode = 2; m_end = now + O; m_fails = 0;
            end else if (m_mode == 0) begin
                if (press) begin m_mode = 1; m_end = now + E; end
            end else if (m_mode == 1) begin
                if (press) m_end = now + E;
                else if (now == m_end) begin
                    if (m_fails + 1 == MF) begin m_mode = 3; m_fails = MF; m_end = now + L; end
                    else begin m_mode = 0; m_fails = m_fails + 1; end
                end
            end else if (now == m_end) begin
                if (m_mode == 3) m_fails = 0;
                m_mode = 0;
            end
            m_clr = (m_mode == 0) && (old != 0);
        end
        now++;
    end

    always @(posedge clk) begin : compare
        #3;
        if (m_valid) begin
            chk("state", 16'(state), 16'(m_mode));
            chk("fail_cnt", 16'(fail_cnt), 16'(m_fails));
            chk("unlocked", 16'(unlocked), 16'(m_mode == 2));
            chk("alarm", 16'(alarm), 16'(m_mode == 3));
            chk("det_clr", 16'(det_clr), 16'(m_clr));
            chk("det_left", 16'(det_left), 16'(left && m_mode < 2));
            chk("det_right", 16'(det_right), 16'(right && m_mode < 2));
        end
    end

    task automatic step(input bit r, input bit l, input bit ri, input bit m);
        @(negedge clk);
        rst = r; left = l; right = ri; match = m;
        @(posedge clk);
        #4;
    endtask

    initial begin : stim
        bit lv, rv, mv, rs;
        lv = 1'b0; rv = 1'b0;

        // Reset and release
        repeat (3) step(1, 0, 0, 0);
        chk("rst_state", 16'(state), 16'd0);
        chk("rst_det_clr", 16'(det_clr), 16'd1);
        chk("rst_fail", 16'(fail_cnt), 16'd0);
        chk("rst_unlocked", 16'(unlocked), 16'd0);
        chk("rst_alarm", 16'(alarm), 16'd0);
        step(0, 0, 0, 0);
        chk("clr_drop", 16'(det_clr), 16'd0);

        // Press left, match three cycles later
        step(0, 1, 0, 0);
        chk("entry_state", 16'(state), 16'd1);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        step(0, 0, 0, 1);
        chk("open_state", 16'(state), 16'd2);
        chk("model_open", 16'(m_mode), 16'd2);
        chk("open_unlocked", 16'(unlocked), 16'd1);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0);
            chk("open_hold", 16'(unlocked), 16'd1);
        end
        step(0, 0, 0, 0);
        chk("open_exit_state", 16'(state), 16'd0);
        chk("open_exit_unlocked", 16'(unlocked), 16'd0);
        chk("open_exit_clr", 16'(det_clr), 16'd1);
        chk("open_exit_fail", 16'(fail_cnt), 16'd0);
        step(0, 0, 0, 0);
        chk("open_clr_drop", 16'(det_clr), 16'd0);

        // Three timed-out attempts into lockout
        for (int a = 1; a <= 3; a++) begin
            step(0, 1, 0, 0);
            repeat (7) step(0, 0, 0, 0);
            chk("entry_last_cycle", 16'(state), 16'd1);
            step(0, 0, 0, 0);
            if (a < 3) begin
                chk("fail_state", 16'(state), 16'd0);
                chk("fail_count", 16'(fail_cnt), 16'(a));
                chk("model_fails", 16'(m_fails), 16'(a));
                chk("fail_clr", 16'(det_clr), 16'd1);
            end else begin
                chk("lock_state", 16'(state), 16'd3);
                chk("lock_fail", 16'(fail_cnt), 16'd3);
                chk("lock_alarm", 16'(alarm), 16'd1);
            end
        end
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 1, (i == 1));
            chk("lock_alarm_hold", 16'(alarm), 16'd1);
            chk("lock_det_left", 16'(det_left), 16'd0);
            chk("lock_det_right", 16'(det_right), 16'd0);
        end
        step(0, 1, 1, 0);
        chk("lock_exit_state", 16'(state), 16'd0);
        chk("lock_exit_fail", 16'(fail_cnt), 16'd0);
        chk("lock_exit_alarm", 16'(alarm), 16'd0);
        step(0, 1, 1, 0);
        chk("held_no_press", 16'(state), 16'd0);
        step(0, 0, 0, 0);

        // Press on the expiry cycle reloads; match on the expiry cycle opens
        step(0, 1, 0, 0);
        repeat (7) step(0, 0, 0, 0);
        step(0, 0, 1, 0);
        chk("expiry_press_state", 16'(state), 16'd1);
        chk("expiry_press_fail", 16'(fail_cnt), 16'd0);
        repeat (7) step(0, 0, 0, 0);
        chk("reload_len", 16'(state), 16'd1);
        step(0, 0, 0, 1);
        chk("expiry_match", 16'(state), 16'd2);
        repeat (4) step(0, 0, 0, 0);
        chk("expiry_open_exit", 16'(state), 16'd0);

        // Reset during the third lockout cycle
        for (int a = 0; a < 3; a++) begin
            step(0, 1, 0, 0);
            repeat (8) step(0, 0, 0, 0);
        end
        chk("lock2_state", 16'(state), 16'd3);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        chk("abort_alarm", 16'(alarm), 16'd0);
        chk("abort_state", 16'(state), 16'd0);
        chk("abort_fail", 16'(fail_cnt), 16'd0);
        step(0, 0, 0, 0);

        // Random traffic
        repeat (3000) begin
            if ($urandom_range(0, 11) == 0) lv = ~lv;
            if ($urandom_range(0, 13) == 0) rv = ~rv;
            mv = ($urandom_range(0, 39) == 0);
            rs = ($urandom_range(0, 499) == 0);
            step(rs, lv, rv, mv);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
